// File: rtl/pswa_pkg.sv
// pswa_pkg: shared types and sizing helpers for the packet symbol width adapter
package pswa_pkg;

   typedef enum logic {IDLE, PACK} state_t;

   function automatic int pswa_ratio(input int out_w, input int in_w);
      return out_w / in_w;
   endfunction

   function automatic int pswa_empty_w(input int ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction

endpackage

// File: rtl/pswa_out_stage.sv
// pswa_out_stage: one-entry output holding register with valid/ready handshake
module pswa_out_stage #(
   parameter int DW = 256,
   parameter int EW = 3
) (
   input  logic          clock_clk,
   input  logic          reset_reset_n,
   input  logic          load,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_sop,
   input  logic          ld_eop,
   input  logic [EW-1:0] ld_empty,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic          sop,
   output logic          eop,
   output logic [EW-1:0] empty,
   output logic          full
);

   assign full = valid;

   // Reload has priority over drain so a word can leave and the next arrive in one cycle
   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         sop   <= 1'b0;
         eop   <= 1'b0;
         empty <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= ld_data;
         sop   <= ld_sop;
         eop   <= ld_eop;
         empty <= ld_empty;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/packet_symbol_width_adapter_rx.sv
// packet_symbol_width_adapter_rx: packs narrow Avalon-ST beats MSB-first into wide words.
// Optional error counter output enabled by macro PSWA_RX_ERROR_STATUS_EN.
module packet_symbol_width_adapter_rx
   import pswa_pkg::*;
#(
   parameter int INPUT_SYMBOL_WIDTH  = 32,
   parameter int OUTPUT_SYMBOL_WIDTH = 256,
   localparam int RATIO = pswa_ratio(OUTPUT_SYMBOL_WIDTH, INPUT_SYMBOL_WIDTH),
   localparam int EW    = pswa_empty_w(RATIO)
) (
   input  logic                           clock_clk,
   input  logic                           reset_reset_n,
   input  logic [INPUT_SYMBOL_WIDTH-1:0]  asi_in0_data,
   input  logic                           asi_in0_valid,
   output logic                           asi_in0_ready,
   input  logic                           asi_in0_startofpacket,
   input  logic                           asi_in0_endofpacket,
   output logic [OUTPUT_SYMBOL_WIDTH-1:0] aso_out0_data,
   output logic                           aso_out0_valid,
   input  logic                           aso_out0_ready,
   output logic                           aso_out0_startofpacket,
   output logic                           aso_out0_endofpacket,
   output logic [EW-1:0]                  aso_out0_empty
`ifdef PSWA_RX_ERROR_STATUS_EN
   ,
   output logic [15:0]                    stat_err_count
`endif
);

   localparam int CW = $clog2(RATIO) + 1;

   if (OUTPUT_SYMBOL_WIDTH % INPUT_SYMBOL_WIDTH != 0 || RATIO < 2) begin : g_bad_ratio
      $error("OUTPUT_SYMBOL_WIDTH must be an integer multiple >= 2 of INPUT_SYMBOL_WIDTH");
   end

   state_t                         state;
   logic [CW-1:0]                  cnt;
   logic [CW-1:0]                  idx;
   logic [OUTPUT_SYMBOL_WIDTH-1:0] buffer;
   logic [OUTPUT_SYMBOL_WIDTH-1:0] merged;
   logic                           first;
   logic                           start;
   logic                           in_pkt;
   logic                           comp;
   logic                           accept;
   logic                           out_full;
   logic [EW-1:0]                  ld_empty;

   assign start  = asi_in0_startofpacket;
   assign in_pkt = (state == PACK);
   assign idx    = start ? '0 : cnt;
   assign comp   = (start | in_pkt) & ((idx == CW'(RATIO - 1)) | asi_in0_endofpacket);
   // A full output register only blocks the beat that would need to load it
   assign asi_in0_ready = !out_full | aso_out0_ready | !comp;
   assign accept   = asi_in0_valid & asi_in0_ready;
   assign ld_empty = asi_in0_endofpacket ? EW'(RATIO - 1 - int'(idx)) : '0;

   // Merge the incoming beat into its slice; a SOP beat ignores any stale partial word
   always_comb begin
      merged = '0;
      for (int i = 0; i < RATIO; i++)
         merged[(RATIO-i)*INPUT_SYMBOL_WIDTH-1 -: INPUT_SYMBOL_WIDTH] =
            (i == int'(idx)) ? asi_in0_data :
            (i < int'(idx) && !start) ? buffer[(RATIO-i)*INPUT_SYMBOL_WIDTH-1 -: INPUT_SYMBOL_WIDTH] : '0;
   end

   // Packet framing state, slice counter and assembly buffer
   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         buffer <= '0;
         first  <= 1'b0;
      end else if (accept && (start || in_pkt)) begin
         if (comp) begin
            buffer <= '0;
            cnt    <= '0;
            first  <= 1'b0;
            state  <= asi_in0_endofpacket ? IDLE : PACK;
         end else begin
            buffer <= merged;
            cnt    <= idx + CW'(1);
            first  <= start | first;
            state  <= PACK;
         end
      end
   end

   pswa_out_stage #(.DW(OUTPUT_SYMBOL_WIDTH), .EW(EW)) u_out (
      .clock_clk     (clock_clk),
      .reset_reset_n (reset_reset_n),
      .load          (accept & comp),
      .ld_data       (merged),
      .ld_sop        (start | first),
      .ld_eop        (asi_in0_endofpacket),
      .ld_empty      (ld_empty),
      .ready         (aso_out0_ready),
      .valid         (aso_out0_valid),
      .data          (aso_out0_data),
      .sop           (aso_out0_startofpacket),
      .eop           (aso_out0_endofpacket),
      .empty         (aso_out0_empty),
      .full          (out_full)
   );

`ifdef PSWA_RX_ERROR_STATUS_EN
   // Saturating count of beats dropped in IDLE and packets aborted by an early SOP
   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         stat_err_count <= '0;
      else if (accept && ((!in_pkt && !start) || (in_pkt && start)) && stat_err_count != 16'hFFFF)
         stat_err_count <= stat_err_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_packet_symbol_width_adapter_rx.sv
// tb_packet_symbol_width_adapter_rx: model-based self-checking bench for the RX width adapter
module tb_packet_symbol_width_adapter_rx;

   localparam int IN  = 32;
   localparam int OUT = 256;
   localparam int R   = 8;

   typedef struct {
      logic [OUT-1:0] d;
      logic           sop;
      logic           eop;
      int             empty;
   } word_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [IN-1:0]  in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           in_sop = 1'b0;
   logic           in_eop = 1'b0;
   logic [OUT-1:0] out_data;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic           out_sop;
   logic           out_eop;
   logic [2:0]     out_empty;
`ifdef PSWA_RX_ERROR_STATUS_EN
   logic [15:0]    err_count;
`endif

   int n_chk = 0;
   int n_fail = 0;
   int stall_cnt = 0;

   word_t         exp_q[$];
   word_t         got_q[$];
   logic [IN-1:0] m_beats[$];
   bit            m_active = 0;
   bit            m_first = 0;
   int            m_err = 0;

   always #5 clk = ~clk;

   packet_symbol_width_adapter_rx #(.INPUT_SYMBOL_WIDTH(IN), .OUTPUT_SYMBOL_WIDTH(OUT)) dut (
      .clock_clk              (clk),
      .reset_reset_n          (rst_n),
      .asi_in0_data           (in_data),
      .asi_in0_valid          (in_valid),
      .asi_in0_ready          (in_ready),
      .asi_in0_startofpacket  (in_sop),
      .asi_in0_endofpacket    (in_eop),
      .aso_out0_data          (out_data),
      .aso_out0_valid         (out_valid),
      .aso_out0_ready         (out_ready),
      .aso_out0_startofpacket (out_sop),
      .aso_out0_endofpacket   (out_eop),
      .aso_out0_empty         (out_empty)
`ifdef PSWA_RX_ERROR_STATUS_EN
      ,
      .stat_err_count         (err_count)
`endif
   );

   task automatic chk(input string nm, input logic [OUT-1:0] act, input logic [OUT-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: collects beats of the current packet and emits whole words
   always @(negedge clk) begin
      bit    exp_v;
      bit    comp;
      int    fill;
      word_t w;
      if (!rst_n) begin
         chk("reset_data", out_data, '0);
         chk("reset_ctl", {out_valid, out_sop, out_eop, out_empty}, '0);
         exp_q.delete();
         m_beats.delete();
         m_active = 0;
         m_first = 0;
         m_err = 0;
      end else begin
         exp_v = (exp_q.size() != 0);
         chk("out_valid", out_valid, exp_v);
         if (exp_v && out_valid) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_ctl", {out_sop, out_eop, out_empty}, {exp_q[0].sop, exp_q[0].eop, 3'(exp_q[0].empty)});
            if (out_ready) begin
               w.d = out_data; w.sop = out_sop; w.eop = out_eop; w.empty = int'(out_empty);
               got_q.push_back(w);
               void'(exp_q.pop_front());
            end
         end
`ifdef PSWA_RX_ERROR_STATUS_EN
         chk("err_count", err_count, 256'(m_err));
`endif
         fill = in_sop ? 1 : m_beats.size() + 1;
         comp = (in_sop || m_active) && (fill == R || in_eop);
         if (in_valid) begin
            chk("in_ready", in_ready, !(exp_v && !out_ready && comp));
            if (!in_ready) stall_cnt++;
         end
         if (in_valid && in_ready) begin
            if (in_sop) begin
               if (m_active) m_err++;
               m_beats.delete();
               m_active = 1;
               m_first = 1;
            end else if (!m_active) begin
               m_err++;
            end
            if (m_active) begin
               m_beats.push_back(in_data);
               if (m_beats.size() == R || in_eop) begin
                  w.d = '0;
                  foreach (m_beats[i]) w.d[OUT-1-IN*i -: IN] = m_beats[i];
                  w.sop = m_first;
                  w.eop = in_eop;
                  w.empty = in_eop ? R - m_beats.size() : 0;
                  exp_q.push_back(w);
                  m_beats.delete();
                  m_first = 0;
                  if (in_eop) m_active = 0;
               end
            end
         end
      end
   end

   task automatic send(input logic [IN-1:0] d, input bit s, input bit e);
      bit acc = 0;
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      chk("accept_timeout", acc, 1);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic pkt(input logic [IN-1:0] base, input int n, input bit with_eop);
      for (int i = 0; i < n; i++) send(base + IN'(i), i == 0, with_eop && i == n - 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_full_packet();
      chk("full_words", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("full_w0", got_q[0].d, 256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);
         chk("full_w0_ctl", {got_q[0].sop, got_q[0].eop}, 2'b10);
         chk("full_w1", got_q[1].d, 256'h00000008_00000009_0000000A_0000000B_0000000C_0000000D_0000000E_0000000F);
         chk("full_w1_ctl", {got_q[1].sop, got_q[1].eop, 3'(got_q[1].empty)}, 5'b01_000);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      #1 chk("ready_after_reset", in_ready, 1);

      got_q.delete();
      pkt(32'h0, 16, 1);
      idle(3);
      check_full_packet();

      got_q.delete();
      pkt(32'hA0, 11, 1);
      idle(3);
      chk("tail_words", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("tail_w1", got_q[1].d, {32'hA8, 32'hA9, 32'hAA, 160'h0});
         chk("tail_w1_ctl", {got_q[1].sop, got_q[1].eop, 3'(got_q[1].empty)}, 5'b01_101);
      end

      got_q.delete();
      send(32'hDEADBEEF, 1, 1);
      idle(3);
      chk("single_words", got_q.size(), 1);
      if (got_q.size() == 1) begin
         chk("single_w", got_q[0].d, {32'hDEADBEEF, 224'h0});
         chk("single_ctl", {got_q[0].sop, got_q[0].eop, 3'(got_q[0].empty)}, 5'b11_111);
      end

      got_q.delete();
      stall_cnt = 0;
      fork
         pkt(32'h100, 16, 1);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (20) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(3);
      chk("bp_words", got_q.size(), 2);
      chk("bp_stalled", stall_cnt > 0, 1);
      if (got_q.size() == 2) begin
         chk("bp_w0_low", got_q[0].d[IN-1:0], 32'h107);
         chk("bp_w1_low", got_q[1].d[IN-1:0], 32'h10F);
      end

      got_q.delete();
      send(32'h11, 0, 0);
      send(32'h12, 0, 0);
      send(32'h13, 0, 0);
      pkt(32'h21, 4, 0);
      send(32'h31, 1, 0);
      send(32'h32, 0, 1);
      idle(3);
      chk("err_words", got_q.size(), 1);
      if (got_q.size() == 1) begin
         chk("err_w", got_q[0].d, {32'h31, 32'h32, 192'h0});
         chk("err_ctl", {got_q[0].sop, got_q[0].eop, 3'(got_q[0].empty)}, 5'b11_110);
      end
`ifdef PSWA_RX_ERROR_STATUS_EN
      chk("err_count_final", err_count, 4);
`endif

      pkt(32'h40, 5, 0);
      #2 rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      got_q.delete();
      pkt(32'h0, 16, 1);
      idle(3);
      check_full_packet();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
